// File: rtl/spi_regfile_pkg.sv
// Shared frame geometry and FSM state encoding for the SPI register-file responder.
package spi_regfile_pkg;

    localparam int CMD_BITS  = 16;
    localparam int DATA_BITS = 16;
    localparam int IDX_W     = 5;
    localparam int WR_BIT    = 31;

    typedef enum logic [2:0] {
        WAIT_IDLE,
        IDLE,
        CMD,
        DATA,
        DONE
    } state_e;

endpackage

// File: rtl/spi_edge_sync.sv
// Multi-bit synchroniser with a history flop for edge detection on asynchronous inputs.
module spi_edge_sync #(
    parameter int WIDTH  = 3,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] async_i,
    output logic [WIDTH-1:0] level_o,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o
);

    logic [WIDTH-1:0] sync_q [STAGES];
    logic [WIDTH-1:0] hist_q;

    // Shift the raw inputs through the synchroniser chain and keep one extra history sample.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < STAGES; i++) begin
                sync_q[i] <= '0;
            end
            hist_q <= '0;
        end else begin
            sync_q[0] <= async_i;
            for (int i = 1; i < STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            hist_q <= sync_q[STAGES-1];
        end
    end

    assign level_o = sync_q[STAGES-1];
    assign rise_o  = sync_q[STAGES-1] & ~hist_q;
    assign fall_o  = ~sync_q[STAGES-1] & hist_q;

endmodule

// File: rtl/spi_slave_regfile.sv
// SPI mode-0 responder: 32-bit command frames write or read a bank of 16-bit registers.
module spi_slave_regfile
    import spi_regfile_pkg::*;
#(
    parameter logic [14:0] ADDR_BASE   = 15'h0000,
    parameter int          NUM_REGS    = 32,
    parameter int          SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     sclk,
    input  logic                     ss_n,
    input  logic                     mosi,
    output logic                     miso,
    output logic                     miso_oe,
    output logic [16*NUM_REGS-1:0]   regs_o,
    output logic                     wr_strb,
    output logic [IDX_W-1:0]         wr_addr,
    output logic [15:0]              wr_data
);

    logic [2:0] syncLevel, syncRise, syncFall;
    logic       sclkRise, sclkFall, ssHigh, ssFall, mosiBit;
    logic       unusedSync;

    spi_edge_sync #(
        .WIDTH  (3),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .reset   (reset),
        .async_i ({mosi, ss_n, sclk}),
        .level_o (syncLevel),
        .rise_o  (syncRise),
        .fall_o  (syncFall)
    );

    assign sclkRise = syncRise[0];
    assign sclkFall = syncFall[0];
    assign ssHigh   = syncLevel[1];
    assign ssFall   = syncFall[1];
    assign mosiBit  = syncLevel[2];

    state_e           state_q, state_d;
    logic [4:0]       bitCnt_q, bitCnt_d;
    logic [15:0]      shift_q, shift_d;
    logic [15:0]      rdShift_q, rdShift_d;
    logic             isWrite_q, isWrite_d;
    logic             hit_q, hit_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             miso_q, miso_d;
    logic             misoOe_q, misoOe_d;
    logic             commit_q, commit_d;
    logic [15:0]      commitData_q, commitData_d;

    logic [15:0]      regs_q [NUM_REGS];
    logic             wrStrb_q;
    logic [IDX_W-1:0] wrAddr_q;
    logic [15:0]      wrData_q;

    logic [15:0]      cmdWord;
    logic [IDX_W-1:0] cmdIdx;
    logic             cmdHit;

    assign cmdWord = {shift_q[14:0], mosiBit};
    assign cmdIdx  = cmdWord[IDX_W-1:0];
    assign cmdHit  = (cmdWord[14:5] == ADDR_BASE[14:5]);

    assign unusedSync = ^{syncLevel[0], syncRise[2:1], syncFall[2], shift_q[15]};

    // Frame FSM state and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= WAIT_IDLE;
            bitCnt_q     <= '0;
            shift_q      <= '0;
            rdShift_q    <= '0;
            isWrite_q    <= 1'b0;
            hit_q        <= 1'b0;
            idx_q        <= '0;
            miso_q       <= 1'b0;
            misoOe_q     <= 1'b0;
            commit_q     <= 1'b0;
            commitData_q <= '0;
        end else begin
            state_q      <= state_d;
            bitCnt_q     <= bitCnt_d;
            shift_q      <= shift_d;
            rdShift_q    <= rdShift_d;
            isWrite_q    <= isWrite_d;
            hit_q        <= hit_d;
            idx_q        <= idx_d;
            miso_q       <= miso_d;
            misoOe_q     <= misoOe_d;
            commit_q     <= commit_d;
            commitData_q <= commitData_d;
        end
    end

    // Next-state logic: command capture, read shift-out, data capture and abort handling.
    always_comb begin
        state_d      = state_q;
        bitCnt_d     = bitCnt_q;
        shift_d      = shift_q;
        rdShift_d    = rdShift_q;
        isWrite_d    = isWrite_q;
        hit_d        = hit_q;
        idx_d        = idx_q;
        miso_d       = miso_q;
        misoOe_d     = misoOe_q;
        commit_d     = 1'b0;
        commitData_d = commitData_q;

        case (state_q)
            WAIT_IDLE: begin
                miso_d   = 1'b0;
                misoOe_d = 1'b0;
                if (ssHigh) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                miso_d   = 1'b0;
                misoOe_d = 1'b0;
                if (ssFall) begin
                    state_d  = CMD;
                    bitCnt_d = '0;
                    shift_d  = '0;
                end
            end
            CMD: begin
                if (ssHigh) begin
                    state_d = IDLE;
                end else if (sclkRise) begin
                    shift_d  = cmdWord;
                    bitCnt_d = bitCnt_q + 5'd1;
                    if (bitCnt_q == 5'(CMD_BITS - 1)) begin
                        isWrite_d = cmdWord[WR_BIT-DATA_BITS];
                        hit_d     = cmdHit;
                        idx_d     = cmdIdx;
                        rdShift_d = (!cmdWord[WR_BIT-DATA_BITS] && cmdHit) ? regs_q[cmdIdx] : '0;
                        state_d   = DATA;
                    end
                end
            end
            DATA: begin
                if (ssHigh) begin
                    state_d  = IDLE;
                    miso_d   = 1'b0;
                    misoOe_d = 1'b0;
                end else if (sclkFall) begin
                    if (!isWrite_q && hit_q) begin
                        miso_d   = rdShift_q[15];
                        misoOe_d = 1'b1;
                    end
                    rdShift_d = {rdShift_q[14:0], 1'b0};
                end else if (sclkRise) begin
                    shift_d  = cmdWord;
                    bitCnt_d = bitCnt_q + 5'd1;
                    if (bitCnt_q == 5'(CMD_BITS + DATA_BITS - 1)) begin
                        state_d  = DONE;
                        miso_d   = 1'b0;
                        misoOe_d = 1'b0;
                        if (isWrite_q && hit_q) begin
                            commit_d     = 1'b1;
                            commitData_d = cmdWord;
                        end
                    end
                end
            end
            DONE: begin
                miso_d   = 1'b0;
                misoOe_d = 1'b0;
                if (ssHigh) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = WAIT_IDLE;
            end
        endcase
    end

    // Register bank and write-report outputs update together one cycle after a commit.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            wrStrb_q <= 1'b0;
            wrAddr_q <= '0;
            wrData_q <= '0;
        end else begin
            wrStrb_q <= commit_q;
            if (commit_q) begin
                regs_q[idx_q] <= commitData_q;
                wrAddr_q      <= idx_q;
                wrData_q      <= commitData_q;
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs_o[16*g +: 16] = regs_q[g];
    end

    assign miso    = miso_q;
    assign miso_oe = misoOe_q;
    assign wr_strb = wrStrb_q;
    assign wr_addr = wrAddr_q;
    assign wr_data = wrData_q;

endmodule

// File: tb/tb_spi_slave_regfile.sv
// Scoreboard bench for spi_slave_regfile: directed SPI frames, queued expectations, decoupled monitors.
module tb_spi_slave_regfile;

    localparam int HALF = 40;

    logic         clk;
    logic         reset;
    logic         sclk;
    logic         ss_n;
    logic         mosi;
    logic         miso;
    logic         miso_oe;
    logic [511:0] regs_o;
    logic         wr_strb;
    logic [4:0]   wr_addr;
    logic [15:0]  wr_data;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [4:0]  addr;
        logic [15:0] data;
    } wrExp_t;

    wrExp_t      wrQueue [$];
    logic [15:0] rdQueue [$];
    logic [15:0] expRegs [32];

    logic [15:0] rdBits;
    int          rdCount = 0;

    spi_slave_regfile #(
        .ADDR_BASE   (15'h0000),
        .NUM_REGS    (32),
        .SYNC_STAGES (2)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .sclk    (sclk),
        .ss_n    (ss_n),
        .mosi    (mosi),
        .miso    (miso),
        .miso_oe (miso_oe),
        .regs_o  (regs_o),
        .wr_strb (wr_strb),
        .wr_addr (wr_addr),
        .wr_data (wr_data)
    );

    // Core clock, 10 ns period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [511:0] actual, input logic [511:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, required);
        end
    endtask

    function automatic logic [511:0] packModel();
        logic [511:0] v;
        for (int i = 0; i < 32; i++) begin
            v[16*i +: 16] = expRegs[i];
        end
        return v;
    endfunction

    // Drive one frame MSB first from word[63]; stops after nBits, optionally pulses reset before bit resetAt.
    task automatic applyStimulus(input logic [63:0] word, input int nBits, input logic expOe, input int resetAt);
        ss_n = 1'b0;
        #(2*HALF);
        for (int i = 0; i < nBits; i++) begin
            if (i == resetAt) begin
                reset = 1'b1;
                #20;
                checkOutput("reset_miso", miso, 1'b0);
                checkOutput("reset_miso_oe", miso_oe, 1'b0);
                checkOutput("reset_wr_strb", wr_strb, 1'b0);
                checkOutput("reset_wr_addr", wr_addr, 5'd0);
                checkOutput("reset_wr_data", wr_data, 16'd0);
                checkOutput("reset_regs", regs_o, 512'd0);
                reset = 1'b0;
                for (int r = 0; r < 32; r++) begin
                    expRegs[r] = 16'h0;
                end
            end
            mosi = word[63-i];
            #HALF;
            if (i == 16) begin
                checkOutput("oe_after_16th_fall", miso_oe, expOe);
            end
            if (i >= 32) begin
                checkOutput("overlength_miso", miso, 1'b0);
                checkOutput("overlength_oe", miso_oe, 1'b0);
            end
            sclk = 1'b1;
            #HALF;
            if (i == 15) begin
                checkOutput("oe_before_16th_fall", miso_oe, 1'b0);
            end
            sclk = 1'b0;
        end
        #HALF;
        ss_n = 1'b1;
        #80;
        checkOutput("oe_after_ss_high", miso_oe, 1'b0);
        checkOutput("miso_after_ss_high", miso, 1'b0);
        #120;
    endtask

    // Write-report monitor: every wr_strb pulse must match the head of the write queue.
    always @(negedge clk) begin
        if (reset === 1'b0 && wr_strb === 1'b1) begin
            if (wrQueue.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_wr_strb: actual addr=%0d data=%h required=no write", wr_addr, wr_data);
            end else begin
                wrExp_t e;
                e = wrQueue.pop_front();
                checkOutput("wr_addr", wr_addr, e.addr);
                checkOutput("wr_data", wr_data, e.data);
                checkOutput("regs_o_at_strb", regs_o[16*int'(e.addr) +: 16], e.data);
            end
        end
    end

    // Read monitor: capture miso on SCLK rises while enabled.
    always @(posedge sclk) begin
        if (miso_oe === 1'b1) begin
            rdBits = {rdBits[14:0], miso};
            rdCount++;
        end
    end

    // Read monitor: on frame end compare the captured word with the head of the read queue.
    always @(posedge ss_n) begin
        if (rdCount != 0) begin
            if (rdQueue.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_read: actual bits=%0d data=%h required=no read", rdCount, rdBits);
            end else begin
                logic [15:0] e;
                e = rdQueue.pop_front();
                checkOutput("read_data", rdBits, e);
                checkOutput("read_bit_count", 32'(rdCount), 32'd16);
            end
            rdCount = 0;
        end
    end

    // Directed sequence.
    initial begin
        reset = 1'b1;
        sclk  = 1'b0;
        ss_n  = 1'b1;
        mosi  = 1'b0;
        rdBits = '0;
        for (int r = 0; r < 32; r++) begin
            expRegs[r] = 16'h0;
        end
        #100;
        checkOutput("init_miso", miso, 1'b0);
        checkOutput("init_miso_oe", miso_oe, 1'b0);
        checkOutput("init_wr_strb", wr_strb, 1'b0);
        checkOutput("init_wr_addr", wr_addr, 5'd0);
        checkOutput("init_wr_data", wr_data, 16'd0);
        checkOutput("init_regs", regs_o, 512'd0);
        reset = 1'b0;
        #200;

        wrQueue.push_back('{addr: 5'd3, data: 16'hABCD});
        expRegs[3] = 16'hABCD;
        applyStimulus({32'h8003ABCD, 32'h0}, 32, 1'b0, -1);
        checkOutput("regs_after_wr3", regs_o, packModel());

        rdQueue.push_back(16'hABCD);
        applyStimulus({32'h00030000, 32'h0}, 32, 1'b1, -1);

        applyStimulus({32'h80401234, 32'h0}, 32, 1'b0, -1);
        checkOutput("regs_after_miss_wr", regs_o, packModel());
        applyStimulus({32'h00400000, 32'h0}, 32, 1'b0, -1);

        applyStimulus({32'h8005FFFF, 32'h0}, 20, 1'b0, -1);
        checkOutput("regs_after_abort", regs_o, packModel());
        wrQueue.push_back('{addr: 5'd5, data: 16'h0042});
        expRegs[5] = 16'h0042;
        applyStimulus({32'h80050042, 32'h0}, 32, 1'b0, -1);
        checkOutput("regs_after_wr5", regs_o, packModel());

        applyStimulus({32'h80071111, 32'h0}, 32, 1'b0, 10);
        checkOutput("regs_after_reset_frame", regs_o, packModel());
        wrQueue.push_back('{addr: 5'd7, data: 16'h2222});
        expRegs[7] = 16'h2222;
        applyStimulus({32'h80072222, 32'h0}, 32, 1'b0, -1);
        checkOutput("regs_after_wr7", regs_o, packModel());
        rdQueue.push_back(16'h2222);
        applyStimulus({32'h00070000, 32'h0}, 32, 1'b1, -1);

        wrQueue.push_back('{addr: 5'd31, data: 16'h5A5A});
        expRegs[31] = 16'h5A5A;
        applyStimulus({32'h801F5A5A, 8'hA5, 24'h0}, 40, 1'b0, -1);
        checkOutput("regs_after_overlength", regs_o, packModel());
        rdQueue.push_back(16'h5A5A);
        applyStimulus({32'h001F0000, 32'h0}, 32, 1'b1, -1);

        #200;
        checkOutput("wr_queue_drained", 32'(wrQueue.size()), 32'd0);
        checkOutput("rd_queue_drained", 32'(rdQueue.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global time limit so the bench always ends.
    initial begin
        #2ms;
        checks++;
        errors++;
        $display("[TB] FAIL timeout: actual=time limit reached required=sequence complete");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_slave_regfile.md
Name: spi_slave_regfile

Overview:
- FPGA-side responder for the CPU's FPGA-register SPI master (one slave-select line).
- Deserialises 32-bit command frames, writes or reads a bank of 16-bit configuration registers, and returns read data on MISO.
- Sits in the core clock domain. SCLK, SS_n and MOSI are treated as asynchronous and oversampled.

Parameters:
ADDR_BASE, 15'h0000, base of the 32-register window; only bits [14:5] are compared.
NUM_REGS, 32, register count; fixed to 32 (5-bit index).
SYNC_STAGES, 2, synchroniser depth on sclk/ss_n/mosi.

Ports:
clk  in  1  core clock; must be >= 8x SCLK frequency
reset  in  1  synchronous, active-high
sclk  in  1  SPI clock, mode 0
ss_n  in  1  slave select, active low
mosi  in  1  serial data in, MSB first
miso  out  1  serial data out
miso_oe  out  1  tristate enable for miso at top level
regs_o  out  512  flattened registers; reg i at [16*i+15:16*i]
wr_strb  out  1  one-cycle pulse per committed write
wr_addr  out  5  register index of last write
wr_data  out  16  data of last write

Behaviour:
- Reset: all regs 0; miso=0, miso_oe=0, wr_strb=0, wr_addr=0, wr_data=0; FSM to WAIT_IDLE.
- Synchronisers:
  - SYNC_STAGES flops plus one history flop on each of sclk, ss_n, mosi.
  - rise/fall = edge of synchronised sclk, one cycle wide.
  - mosi is sampled from the same pipeline stage as the rise detect.
- Frame format, 32 bits MSB first:
  - bit31 = 1 write / 0 read.
  - bits[30:16] = address.
  - bits[15:0] = write data (ignored on reads).
- hit = (addr[14:5] == ADDR_BASE[14:5]); idx = addr[4:0].
- FSM states:
  - WAIT_IDLE: wait for synchronised ss_n=1, then go to IDLE. Entered after reset, so a frame in progress at reset is ignored.
  - IDLE: ss_n falling -> CMD; bit counter=0, shift reg cleared.
  - CMD: shift mosi on each rise; counter++.
    - On the 16th rise, latch rw and addr, compute hit.
    - If read and hit, load rd_shift = regs[idx]; otherwise rd_shift = 0.
    - Go to DATA.
  - DATA:
    - On each fall, miso <= rd_shift[15] and rd_shift shifts left. bit15 is therefore valid before the 17th rise.
    - On each rise, shift mosi into the data shift register.
    - On the 32nd rise, if write and hit: regs[idx] <= data; wr_strb=1 on the next cycle; wr_addr/wr_data updated in the same cycle.
    - Go to DONE.
  - DONE: ignore further edges (miso=0) until ss_n=1 -> IDLE.
- miso_oe = 1 only in DATA for a read with hit, from the 16th fall until ss_n rises or DONE. Otherwise 0, and miso is held 0.
- ss_n deasserting in CMD or DATA: abort, no register write, no wr_strb, miso_oe=0 in the same cycle as detection, go to IDLE.
- regs_o is registered and updates the cycle after the commit, coincident with wr_strb.
- Back-to-back frames need a minimum ss_n high time of 2 SCLK periods.
- Latency from the 32nd SCLK rise at the pin to the regs_o update: SYNC_STAGES+2 clk cycles.
- A write to a register and an immediately following read of it return the new value.

Decomposition:
- Package spi_regfile_pkg:
  - frame constants CMD_BITS=16, DATA_BITS=16, IDX_W=5, WR_BIT=31;
  - FSM state enum.
- Sub-module spi_edge_sync: synchroniser and edge detector, instantiated once with sclk, ss_n and mosi as a 3-bit bus.
- Register array and FSM stay in the top module.

Test Plan:
- Write 0x8003ABCD at SCLK=clk/8 -> regs_o[63:48]=0xABCD; one wr_strb with wr_addr=3, wr_data=0xABCD; other regs unchanged.
- After that write, read frame 0x00030000 -> miso_oe rises at the 16th fall; MISO bits on rises 17-32 = 0xABCD; miso_oe falls when ss_n rises.
- Miss address (ADDR_BASE=0): write 0x8040_1234 -> no wr_strb, all regs unchanged. Read 0x0040_0000 -> miso_oe stays 0.
- Abort: write 0x8005_FFFF with ss_n raised after 20 bits -> reg5 stays 0, no wr_strb. Next full write 0x8005_0042 -> reg5=0x0042.
- Reset asserted mid-frame at bit 10 -> all outputs 0; rest of frame ignored; next frame after ss_n high works normally.
- Over-length frame of 40 bits, write 0x801F_5A5A plus 8 extra bits -> reg31=0x5A5A committed at bit 32; extra bits ignored; miso=0.
